// File: rtl/avalon_master_arbiter_pkg.sv
// Shared types and constants for the two-requester Avalon-MM master arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avalon_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD1BAD1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/avalon_master_arbiter_if.sv
// Bundle of requester-side and fabric-side Avalon-MM signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_waitrequest / master_waitrequest carried as plain signals.
// Ports: modport master = arbiter view (drives fabric command and requester
// responses); modport slave = environment view (requesters plus fabric).
interface avalon_master_arbiter_if
    import avalon_arb_pkg::*;
#(
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32
);
    logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0] req_address;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0]    req_writedata;
    logic [NUM_REQ-1:0]                   req_write;
    logic [NUM_REQ-1:0]                   req_read;
    logic [NUM_REQ-1:0]                   req_waitrequest;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0]    req_readdata;
    logic [NUM_REQ-1:0]                   req_readdatavalid;
    logic [NUM_REQ-1:0]                   req_error;

    logic [ADDRESSWIDTH-1:0]              master_address;
    logic [DATAWIDTH-1:0]                 master_writedata;
    logic                                 master_write;
    logic                                 master_read;
    logic [DATAWIDTH-1:0]                 master_readdata;
    logic                                 master_readdatavalid;
    logic                                 master_waitrequest;

    modport master (
        input  req_address, req_writedata, req_write, req_read,
        output req_waitrequest, req_readdata, req_readdatavalid, req_error,
        output master_address, master_writedata, master_write, master_read,
        input  master_readdata, master_readdatavalid, master_waitrequest
    );

    modport slave (
        output req_address, req_writedata, req_write, req_read,
        input  req_waitrequest, req_readdata, req_readdatavalid, req_error,
        input  master_address, master_writedata, master_write, master_read,
        output master_readdata, master_readdatavalid, master_waitrequest
    );

endinterface

// File: rtl/avalon_master_arbiter_pick.sv
// Round-robin winner pick between two requesters.
// Latency: combinational.
// Backpressure: none; the caller only samples the result when it can grant.
// Ports: req_valid (per-requester request), last_grant (last served), winner.
module rr_pick2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       winner
);

    logic preferred;

    // The requester that was not served last has priority if it is asking;
    // otherwise the grant falls to the other one.
    always_comb begin
        preferred = ~last_grant;
        winner    = last_grant;
        if (req_valid[preferred]) begin
            winner = preferred;
        end
    end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Shares one Avalon-MM master port between two requesters, round-robin per transaction.
// Latency: 1 cycle arbitration, command passes through combinationally; read data pass-through.
// Backpressure: master_waitrequest forwarded to the granted requester only; others held.
// Ports: clk, reset_n (async active-low), bus (arbiter modport), grant_id, busy,
// stray_rdv (sticky flag for a readdatavalid arriving outside RD_WAIT).
module avalon_master_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int                   ADDRESSWIDTH = 26,
    parameter int                   DATAWIDTH    = 32,
    parameter int                   RD_TIMEOUT   = 256,
    parameter logic [DATAWIDTH-1:0] ERR_DATA     = DATAWIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_master_arbiter_if.master bus,
    output logic                    grant_id,
    output logic                    busy,
    output logic                    stray_rdv
);

    localparam int CW = $clog2(RD_TIMEOUT);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            stray_q;
    logic            winner;
    logic            wr;
    logic            rd;

    rr_pick2 u_pick (
        .req_valid  (bus.req_read | bus.req_write),
        .last_grant (last_q),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            // A response nobody is waiting for is dropped and remembered.
            if (bus.master_readdatavalid && (state_q != RD_WAIT)) begin
                stray_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        last_d                = last_q;
        cnt_d                 = cnt_q;
        wr                    = 1'b0;
        rd                    = 1'b0;
        bus.req_waitrequest   = '1;
        bus.req_readdata      = '0;
        bus.req_readdatavalid = '0;
        bus.req_error         = '0;
        bus.master_address    = '0;
        bus.master_writedata  = '0;
        bus.master_write      = 1'b0;
        bus.master_read       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|(bus.req_read | bus.req_write)) begin
                    grant_d = winner;
                    state_d = CMD;
                end
            end

            CMD: begin
                // Write has priority over a simultaneous read from the same
                // requester; a dropped strobe simply parks us here.
                wr = bus.req_write[grant_q];
                rd = bus.req_read[grant_q] & ~wr;
                bus.master_address           = bus.req_address[grant_q];
                bus.master_writedata         = bus.req_writedata[grant_q];
                bus.master_write             = wr;
                bus.master_read              = rd;
                bus.req_waitrequest[grant_q] = bus.master_waitrequest;
                if (!bus.master_waitrequest) begin
                    if (wr) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end else if (rd) begin
                        state_d = RD_WAIT;
                        cnt_d   = '0;
                    end
                end
            end

            RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Real data beats the timeout when both land in one cycle.
                if (bus.master_readdatavalid) begin
                    bus.req_readdata[grant_q]      = bus.master_readdata;
                    bus.req_readdatavalid[grant_q] = 1'b1;
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
                    bus.req_readdata[grant_q]      = ERR_DATA;
                    bus.req_readdatavalid[grant_q] = 1'b1;
                    bus.req_error[grant_q]         = 1'b1;
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
    assign stray_rdv = stray_q;

endmodule
